// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between the MEM pipeline stage and the
// data memory bus.
//
// An access is decoded when it is accepted from the pipeline. Addresses below
// ADDR_FLOOR are raised to it, and the alignment check is applied to the
// raised address. A legal access drives a valid/grant bus request with byte
// enables and lane-replicated store data. For a load, the controller then
// waits for mem_rvalid and returns the addressed bytes, sign- or
// zero-extended. Every accepted access ends in exactly one resp_valid pulse,
// unless reset aborts it.
//
// Parameters:
//   XLEN        data path width (32 or 64)
//   ADDR_FLOOR  lowest effective address
//   TIMEOUT     cycles allowed in REQ+WAIT before a timeout fault (0 = off)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid / req_ready     pipeline handshake (ready only in IDLE)
//   opcode_in, funct3_in      access decode (size in [1:0], unsigned in [2])
//   addr_in, wdata_in         byte address and rs2 store data
//   resp_valid, resp_data     completion pulse and extended load data
//   fault, fault_cause        00 none, 01 misaligned, 10 width, 11 timeout
//   busy                      pipeline stall while an access is in flight
//   mem_req/mem_gnt/mem_we    bus request, grant and write flag
//   mem_addr, mem_be          word-aligned address and byte enables
//   mem_wdata                 lane-replicated store data
//   mem_rvalid, mem_rdata     load data return

`ifndef OPC_LOAD
`define OPC_LOAD 7'b0000011
`endif
`ifndef OPC_STORE
`define OPC_STORE 7'b0100011
`endif

module lsu_ctrl #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] ADDR_FLOOR = XLEN'('h1000),
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [6:0]        opcode_in,
  input  logic [2:0]        funct3_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [XLEN-1:0]   wdata_in,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_data,
  output logic              fault,
  output logic [1:0]        fault_cause,
  output logic              busy,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int CW = $clog2(TIMEOUT + 2) + 1;
  localparam logic [CW:0] TMO = (CW+1)'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state, state_d, acc_state;
  logic              is_store_q, uns_q;
  logic [1:0]        size_q, cause_q, acc_cause;
  logic [XLEN-1:0]   ea_q, wdata_q, rdata_q;
  logic [NB-1:0]     be_q, be_d;
  logic [CW-1:0]     cnt_q;
  logic [CW:0]       elapsed;

  logic              accept, tmo_hit, tmo_fire, load_done;
  logic              is_load, is_store, misaligned, illegal_width;
  logic [XLEN-1:0]   ea, wdata_d, shifted, mask, load_ext;
  logic [OW-1:0]     off_in;
  logic              sbit;

  // Decode of the access currently offered by the pipeline. The address
  // clamp comes first, so alignment is judged on the address actually used.
  // The result picks the state to enter on acceptance. Non-memory opcodes
  // pass straight to DONE with no fault. Illegal widths and misaligned
  // accesses also go to DONE, but with their fault cause.
  always_comb begin
    ea            = (addr_in < ADDR_FLOOR) ? ADDR_FLOOR : addr_in;
    off_in        = ea[OW-1:0];
    is_load       = (opcode_in == `OPC_LOAD);
    is_store      = (opcode_in == `OPC_STORE);
    illegal_width = (funct3_in[1:0] == 2'b11) && (XLEN == 32);
    misaligned    = 1'b0;
    unique case (funct3_in[1:0])
      2'b01:   misaligned = ea[0];
      2'b10:   misaligned = |ea[1:0];
      2'b11:   misaligned = |ea[2:0];
      default: misaligned = 1'b0;
    endcase
    acc_cause = 2'b00;
    acc_state = REQ;
    if (!is_load && !is_store) begin
      acc_state = DONE;
    end else if (illegal_width) begin
      acc_state = DONE;
      acc_cause = 2'b10;
    end else if (misaligned) begin
      acc_state = DONE;
      acc_cause = 2'b01;
    end
  end

  // Byte enables and store data are worked out once, at acceptance. The
  // registered copies then stay stable for the whole bus request. Narrow
  // store data is copied to every lane, so the memory can pick the lane
  // selected by the byte enables.
  always_comb begin
    be_d    = '1;
    wdata_d = wdata_in;
    unique case (funct3_in[1:0])
      2'b00: begin
        be_d    = NB'(1) << off_in;
        wdata_d = {NB{wdata_in[7:0]}};
      end
      2'b01: begin
        be_d    = NB'(3) << off_in;
        wdata_d = {(NB/2){wdata_in[15:0]}};
      end
      2'b10: begin
        be_d    = NB'(15) << off_in;
        wdata_d = {(XLEN/32){wdata_in[31:0]}};
      end
      default: begin
        be_d    = '1;
        wdata_d = wdata_in;
      end
    endcase
  end

  // Load return path. The bus word is shifted down so the addressed byte
  // lands in lane 0, then truncated to the access size. Bits above the
  // access size are filled with the sign bit, or with zeros for the
  // unsigned variants.
  always_comb begin
    shifted = mem_rdata >> {ea_q[OW-1:0], 3'b000};
    mask    = '1;
    sbit    = shifted[XLEN-1];
    unique case (size_q)
      2'b00: begin
        mask = XLEN'(8'hFF);
        sbit = shifted[7];
      end
      2'b01: begin
        mask = XLEN'(16'hFFFF);
        sbit = shifted[15];
      end
      2'b10: begin
        mask = XLEN'(32'hFFFF_FFFF);
        sbit = shifted[31];
      end
      default: begin
        mask = '1;
        sbit = shifted[XLEN-1];
      end
    endcase
    load_ext = (shifted & mask) | ((!uns_q && sbit) ? ~mask : '0);
  end

  // elapsed counts the cycles spent in REQ+WAIT, including the current one.
  // The timeout fires on the cycle where this count reaches TIMEOUT, unless
  // that cycle also carries the grant or read data the access was waiting
  // for.
  assign elapsed = {1'b0, cnt_q} + (CW+1)'(1);
  assign tmo_hit = (TIMEOUT != 0) && (elapsed >= TMO);

  // Next-state logic. It also raises single-cycle flags that tell the
  // datapath register block when to accept an access, record a timeout, or
  // capture load data.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    tmo_fire  = 1'b0;
    load_done = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          accept  = 1'b1;
          state_d = acc_state;
        end
      end
      REQ: begin
        if (mem_gnt) begin
          state_d = is_store_q ? DONE : WAIT;
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d   = DONE;
          load_done = 1'b1;
        end else if (tmo_hit) begin
          state_d  = DONE;
          tmo_fire = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register. Reset returns to IDLE immediately. All outputs are
  // decoded from the state, so reset also drops an in-flight request and
  // cancels its response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Access context registers. At acceptance they capture the decoded
  // access, the initial fault cause, and a cleared load-data register, so
  // stores and faults respond with zero data. After that, only the timeout
  // counter, a timeout cause, or returned load data update them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      ea_q       <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      cause_q    <= 2'b00;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      is_store_q <= is_store;
      uns_q      <= funct3_in[2];
      size_q     <= funct3_in[1:0];
      ea_q       <= ea;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      cause_q    <= acc_cause;
      rdata_q    <= '0;
      cnt_q      <= '0;
    end else begin
      if (state == REQ || state == WAIT) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (tmo_fire) begin
        cause_q <= 2'b11;
      end
      if (load_done) begin
        rdata_q <= load_ext;
      end
    end
  end

  // Output decode. Bus fields are driven only while requesting, and
  // response fields only during the DONE pulse. At all other times they
  // read as zero.
  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign mem_req     = (state == REQ);
  assign mem_we      = mem_req && is_store_q;
  assign mem_addr    = mem_req ? {ea_q[XLEN-1:OW], {OW{1'b0}}} : '0;
  assign mem_be      = mem_req ? be_q : '0;
  assign mem_wdata   = mem_req ? wdata_q : '0;
  assign resp_valid  = (state == DONE);
  assign resp_data   = resp_valid ? rdata_q : '0;
  assign fault       = resp_valid && (cause_q != 2'b00);
  assign fault_cause = resp_valid ? cause_q : 2'b00;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl (XLEN=32, TIMEOUT=4).
//
// Each access is run through applyStimulus. The expected address, enables,
// store data, load result, fault cause and response cycle are computed
// there from plain arithmetic on the access. The bench then drives grant
// and read-data timing and compares the DUT cycle by cycle.

module tb_lsu_ctrl;

  localparam int T = 4;
  localparam logic [6:0] OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  opcode_in;
  logic [2:0]  funct3_in;
  logic [31:0] addr_in;
  logic [31:0] wdata_in;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        fault;
  logic [1:0]  fault_cause;
  logic        busy;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .XLEN(32),
    .ADDR_FLOOR(32'h1000),
    .TIMEOUT(T)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .opcode_in(opcode_in),
    .funct3_in(funct3_in),
    .addr_in(addr_in),
    .wdata_in(wdata_in),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .fault(fault),
    .fault_cause(fault_cause),
    .busy(busy),
    .mem_req(mem_req),
    .mem_gnt(mem_gnt),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_be(mem_be),
    .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Runs one access from the IDLE state to its response pulse.
  // Grant arrives dg cycles after the request starts. For loads, read data
  // arrives dr cycles after the cycle following the grant. A value of 99
  // means the event never arrives. If noise is set, a junk rvalid is
  // driven in the grant cycle.
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rd, input int dg, input int dr,
                               input bit noise);
    logic [31:0] ea, exp_addr, exp_wd, exp_data, mask, v;
    logic [3:0]  exp_be;
    logic [1:0]  exp_cause;
    int          nbytes, off, gc, rvc, resp_c, req_end;
    bit          is_ld, is_st, go_bus;

    is_ld  = (op == OPC_LD);
    is_st  = (op == OPC_ST);
    ea     = (addr < 32'h1000) ? 32'h1000 : addr;
    nbytes = 1 << f3[1:0];
    off    = int'(ea % 4);
    exp_cause = 2'd0;
    go_bus = 1'b0;
    if (!(is_ld || is_st)) begin
      go_bus = 1'b0;
    end else if (f3[1:0] == 2'b11) begin
      exp_cause = 2'd2;
    end else if ((ea % nbytes) != 0) begin
      exp_cause = 2'd1;
    end else begin
      go_bus = 1'b1;
    end
    exp_addr = ea & 32'hFFFF_FFFC;
    exp_be   = 4'(((1 << nbytes) - 1) << off);
    case (nbytes)
      1:       exp_wd = {24'h0, wd[7:0]} * 32'h0101_0101;
      2:       exp_wd = {16'h0, wd[15:0]} * 32'h0001_0001;
      default: exp_wd = wd;
    endcase
    mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * nbytes)) - 32'h1);
    v = (rd >> (8 * off)) & mask;
    if (!f3[2] && v[8 * nbytes - 1]) v = v | ~mask;

    gc  = 1 + dg;
    rvc = gc + 1 + dr;
    exp_data = 32'h0;
    if (!go_bus) begin
      resp_c  = 1;
      req_end = 0;
    end else if (is_st) begin
      if (gc <= T) begin
        resp_c = gc + 1;
      end else begin
        resp_c = T + 1;
        exp_cause = 2'd3;
      end
      req_end = (gc <= T) ? gc : T;
    end else begin
      if (gc <= T && rvc <= T) begin
        resp_c = rvc + 1;
        exp_data = v;
      end else begin
        resp_c = T + 1;
        exp_cause = 2'd3;
      end
      req_end = (gc <= T) ? gc : T;
    end

    @(negedge clk);
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    checkOutput("idle_ready", 32'(req_ready), 32'd1);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_resp_valid", 32'(resp_valid), 32'd0);
    req_valid = 1'b1;
    opcode_in = op;
    funct3_in = f3;
    addr_in   = addr;
    wdata_in  = wd;

    for (int c = 1; c <= resp_c; c++) begin
      @(negedge clk);
      req_valid  = 1'b0;
      opcode_in  = 7'($urandom);
      addr_in    = $urandom;
      wdata_in   = $urandom;
      mem_gnt    = (c == gc);
      mem_rvalid = (c == rvc) || (noise && c == gc);
      mem_rdata  = (c == rvc) ? rd : $urandom;
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("mem_req", 32'(mem_req), 32'(c <= req_end));
      if (c <= req_end) begin
        checkOutput("mem_we", 32'(mem_we), 32'(is_st));
        checkOutput("mem_addr", mem_addr, exp_addr);
        checkOutput("mem_be", 32'(mem_be), 32'(exp_be));
        if (is_st) checkOutput("mem_wdata", mem_wdata, exp_wd);
      end
      checkOutput("resp_valid", 32'(resp_valid), 32'(c == resp_c));
      if (c == resp_c) begin
        checkOutput("resp_data", resp_data, exp_data);
        checkOutput("fault", 32'(fault), 32'(exp_cause != 2'd0));
        checkOutput("fault_cause", 32'(fault_cause), 32'(exp_cause));
      end
    end
  endtask

  initial begin
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          dg, dr;

    rst        = 1'b1;
    req_valid  = 1'b0;
    opcode_in  = 7'h0;
    funct3_in  = 3'h0;
    addr_in    = 32'h0;
    wdata_in   = 32'h0;
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(req_ready), 32'd1);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fault", 32'(fault), 32'd0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'd0);
    rst = 1'b0;

    $display("[TB] directed accesses");
    applyStimulus(OPC_LD, 3'b010, 32'h2004, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0);
    applyStimulus(OPC_LD, 3'b000, 32'h2003, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
    applyStimulus(OPC_LD, 3'b100, 32'h2003, 32'h0, 32'h80FF_FFFF, 0, 0, 1'b0);
    applyStimulus(OPC_ST, 3'b001, 32'h0010, 32'h1234_ABCD, 32'h0, 0, 0, 1'b0);
    applyStimulus(OPC_LD, 3'b010, 32'h2002, 32'h0, 32'h0, 0, 0, 1'b0);
    applyStimulus(OPC_ST, 3'b011, 32'h2000, 32'h5555_AAAA, 32'h0, 0, 0, 1'b0);
    applyStimulus(7'h33, 3'b010, 32'h2000, 32'h0, 32'h0, 0, 0, 1'b0);
    applyStimulus(OPC_LD, 3'b010, 32'h3000, 32'h0, 32'h0, 99, 0, 1'b0);
    applyStimulus(OPC_LD, 3'b001, 32'h3002, 32'h0, 32'h0, 0, 99, 1'b0);
    applyStimulus(OPC_ST, 3'b010, 32'h3008, 32'hCAFE_F00D, 32'h0, 3, 0, 1'b0);
    applyStimulus(OPC_ST, 3'b010, 32'h3008, 32'hCAFE_F00D, 32'h0, 4, 0, 1'b0);
    applyStimulus(OPC_LD, 3'b101, 32'h0FFE, 32'h0, 32'h1234_8001, 1, 1, 1'b1);

    $display("[TB] reset during WAIT");
    @(negedge clk);
    req_valid = 1'b1;
    opcode_in = OPC_LD;
    funct3_in = 3'b010;
    addr_in   = 32'h2004;
    @(negedge clk);
    req_valid = 1'b0;
    mem_gnt   = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_ready", 32'(req_ready), 32'd1);
    checkOutput("arst_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("arst_mem_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = (i == 0);
      mem_rdata  = 32'h7777_7777;
      checkOutput("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("post_rst_mem_req", 32'(mem_req), 32'd0);
    end
    applyStimulus(OPC_LD, 3'b010, 32'h2004, 32'h0, 32'h0BAD_F00D, 0, 0, 1'b0);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: op = OPC_LD;
        4, 5, 6, 7: op = OPC_ST;
        8:          op = 7'h13;
        default:    op = 7'h33;
      endcase
      f3   = 3'($urandom_range(0, 7));
      addr = 32'($urandom_range(0, 32'h7FFF));
      if ($urandom_range(0, 2) != 0) addr = addr & (32'hFFFF_FFFF << f3[1:0]);
      if (op == OPC_ST) begin
        dg = int'($urandom_range(0, 4));
        dr = 0;
      end else if ($urandom_range(0, 7) == 0) begin
        dg = 0;
        dr = 99;
      end else begin
        dg = int'($urandom_range(0, 2));
        dr = int'($urandom_range(0, 2 - dg));
      end
      applyStimulus(op, f3, addr, $urandom, $urandom, dg, dr, 1'($urandom_range(0, 1)));
    end

    @(negedge clk);
    checkOutput("final_ready", 32'(req_ready), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
